// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory data port between master 0 (CPU) and
// master 1 (loader/debug); one transaction in flight, req/ack handshake per master.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_aout,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rw_q, rw_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_aout_q, mem_aout_d;
  logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              win;
  logic              finish;

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    mem_aout_d = mem_aout_q;
    mem_dout_d = mem_dout_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    mem_rw_d   = 1'b0;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    win        = 1'b0;
    finish     = 1'b0;

    case (state_q)
      IDLE: begin
        // rr_q holds the last winner; on a tie the other master is served
        win = (m0_req && m1_req) ? ~rr_q : m1_req;
        if (m0_req || m1_req) begin
          grant_d    = win;
          rr_d       = win;
          rw_d       = win ? m1_rw : m0_rw;
          mem_rw_d   = win ? m1_rw : m0_rw;
          mem_aout_d = win ? m1_addr : m0_addr;
          mem_dout_d = win ? m1_wdata : m0_wdata;
          cnt_d      = 3'(READ_LATENCY);
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        finish = rw_q || (cnt_q == 3'd0);
        if (finish) begin
          state_d = DONE;
          if (grant_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = rw_q ? '0 : mem_din;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = rw_q ? '0 : mem_din;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // rr_q resets to 1 so that master 0 wins the first tie
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      cnt_q      <= 3'd0;
      rr_q       <= 1'b1;
      grant_q    <= 1'b0;
      busy_q     <= 1'b0;
      mem_rw_q   <= 1'b0;
      mem_aout_q <= '0;
      mem_dout_q <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      mem_rw_q   <= mem_rw_d;
      mem_aout_q <= mem_aout_d;
      mem_dout_q <= mem_dout_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign m0_ack   = m0_ack_q;
  assign m1_ack   = m1_ack_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign mem_rw   = mem_rw_q;
  assign mem_aout = mem_aout_q;
  assign mem_dout = mem_dout_q;
  assign busy     = busy_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with READ_LATENCY=1 (u0) and one
// with READ_LATENCY=3 (u3), each backed by a small memory model; acks are scoreboarded.
module tb_mem_arbiter;

  logic clock;
  logic reset;

  logic        m0_req, m0_rw, m1_req, m1_rw;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack, mem_rw, busy, grant;
  logic [31:0] m0_rdata, m1_rdata, mem_aout, mem_dout, mem_din;

  logic        b_m0_req, b_m0_rw, b_m1_req, b_m1_rw;
  logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
  logic        b_m0_ack, b_m1_ack, b_mem_rw, b_busy, b_grant;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_aout, b_mem_dout, b_mem_din;

  logic [31:0] mem0 [0:255];
  logic [31:0] mem3 [0:255];

  typedef struct {
    int          who;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  int compared   = 0;
  int mismatched = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1)) u0 (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_rw(mem_rw), .mem_aout(mem_aout), .mem_dout(mem_dout), .mem_din(mem_din),
    .busy(busy), .grant(grant)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3)) u3 (
    .clock(clock), .reset(reset),
    .m0_req(b_m0_req), .m0_rw(b_m0_rw), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_rw(b_m1_rw), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .mem_rw(b_mem_rw), .mem_aout(b_mem_aout), .mem_dout(b_mem_dout), .mem_din(b_mem_din),
    .busy(b_busy), .grant(b_grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory models: synchronous write on the strobe, combinational read
  always @(posedge clock) begin
    if (mem_rw) mem0[mem_aout[7:0]] <= mem_dout;
    if (b_mem_rw) mem3[b_mem_aout[7:0]] <= b_mem_dout;
  end
  assign mem_din   = mem0[mem_aout[7:0]];
  assign b_mem_din = mem3[b_mem_aout[7:0]];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input int who, input logic [31:0] rdata);
    exp_t e;
    e.who   = who;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int dut, input int master, input logic rw,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic sync);
    if (sync) begin
      @(posedge clock);
      #1;
    end
    if (dut == 0 && master == 0) begin
      m0_rw = rw; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end else if (dut == 0) begin
      m1_rw = rw; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end else if (master == 0) begin
      b_m0_rw = rw; b_m0_addr = addr; b_m0_wdata = wdata; b_m0_req = 1'b1;
    end else begin
      b_m1_rw = rw; b_m1_addr = addr; b_m1_wdata = wdata; b_m1_req = 1'b1;
    end
  endtask

  // Waits (bounded) for an ack; who = -1 on timeout, 2 if both acks fire together
  task automatic waitAck(input int dut, input int budget, input logic [31:0] addr,
                         output int k, output int who, output int rwh, output int acc,
                         output logic [31:0] rd, output logic g);
    logic a0, a1, rwv, bz, gv;
    logic [31:0] r0, r1, ao;
    k = 0; who = -1; rwh = 0; acc = 0; rd = '0; g = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      k++;
      if (dut == 0) begin
        a0 = m0_ack; a1 = m1_ack; rwv = mem_rw; bz = busy; gv = grant;
        r0 = m0_rdata; r1 = m1_rdata; ao = mem_aout;
      end else begin
        a0 = b_m0_ack; a1 = b_m1_ack; rwv = b_mem_rw; bz = b_busy; gv = b_grant;
        r0 = b_m0_rdata; r1 = b_m1_rdata; ao = b_mem_aout;
      end
      if (rwv) rwh++;
      if (bz && !a0 && !a1 && ao == addr) acc++;
      if (a0 || a1) begin
        who = (a0 && a1) ? 2 : (a1 ? 1 : 0);
        rd  = a1 ? r1 : r0;
        g   = gv;
        break;
      end
    end
  endtask

  task automatic expectAck(input int dut, input int exp_k, input logic [31:0] addr,
                           input string tag, output int rwh, output int acc);
    int k, who;
    logic [31:0] rd;
    logic g;
    exp_t e;
    waitAck(dut, 20, addr, k, who, rwh, acc, rd, g);
    if (sb.size() > 0) e = sb.pop_front();
    else begin
      e.who = -2; e.rdata = '0;
    end
    checkOutput({tag, "_who"}, who, e.who);
    checkOutput({tag, "_latency"}, k, exp_k);
    checkOutput({tag, "_rdata"}, rd, e.rdata);
    checkOutput({tag, "_grant"}, g, e.who);
  endtask

  initial begin
    int rwh, acc, k, who;
    logic [31:0] rd;
    logic g;
    exp_t e;

    reset = 1'b0;
    m0_req = 0; m0_rw = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_rw = 0; m1_addr = 0; m1_wdata = 0;
    b_m0_req = 0; b_m0_rw = 0; b_m0_addr = 0; b_m0_wdata = 0;
    b_m1_req = 0; b_m1_rw = 0; b_m1_addr = 0; b_m1_wdata = 0;

    repeat (2) @(negedge clock);
    checkOutput("rst_flags", {busy, grant, mem_rw, m0_ack, m1_ack}, 5'b0);
    checkOutput("rst_aout", mem_aout, 32'h0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
    @(posedge clock);
    #1 reset = 1'b1;

    $display("[TB] write then read back through master 0");
    applyStimulus(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1);
    pushExp(0, 32'h0);
    @(negedge clock);
    checkOutput("t1_idle_busy", busy, 1'b0);
    @(negedge clock);
    checkOutput("t1_rw", mem_rw, 1'b1);
    checkOutput("t1_aout", mem_aout, 32'h10);
    checkOutput("t1_dout", mem_dout, 32'hDEADBEEF);
    checkOutput("t1_busy", busy, 1'b1);
    @(negedge clock);
    checkOutput("t1_acks", {m0_ack, m1_ack}, 2'b10);
    checkOutput("t1_rw_low", mem_rw, 1'b0);
    e = sb.pop_front();
    checkOutput("t1_rdata", m0_rdata, e.rdata);
    m0_req = 1'b0;

    applyStimulus(0, 0, 1'b0, 32'h10, 32'h0, 1'b1);
    pushExp(0, 32'hDEADBEEF);
    expectAck(0, 4, 32'h10, "t2", rwh, acc);
    checkOutput("t2_rw_never", rwh, 0);
    m0_req = 1'b0;

    $display("[TB] both masters requesting continuously from reset");
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    applyStimulus(0, 0, 1'b1, 32'h30, 32'h11111111, 1'b1);
    applyStimulus(0, 1, 1'b1, 32'h40, 32'h22222222, 1'b0);
    pushExp(0, 0); pushExp(1, 0); pushExp(0, 0); pushExp(1, 0);
    for (int i = 0; i < 4; i++) expectAck(0, 3, 32'h0, $sformatf("t3_%0d", i), rwh, acc);
    m0_req = 1'b0;
    m1_req = 1'b0;

    $display("[TB] late master 1 request and post-grant input changes");
    applyStimulus(0, 0, 1'b0, 32'h30, 32'h0, 1'b1);
    pushExp(0, 32'h11111111);
    @(negedge clock);
    @(negedge clock);
    m1_rw = 1'b0; m1_addr = 32'h40; m1_req = 1'b1;
    m0_addr = 32'h10; m0_rw = 1'b1;
    pushExp(1, 32'h22222222);
    expectAck(0, 2, 32'h0, "t5_m0", rwh, acc);
    m0_req = 1'b0; m0_rw = 1'b0;
    expectAck(0, 4, 32'h0, "t5_m1", rwh, acc);
    checkOutput("t5_m0_hold", m0_rdata, 32'h11111111);
    m1_req = 1'b0;

    $display("[TB] reset during a write access");
    applyStimulus(0, 0, 1'b1, 32'h50, 32'h55, 1'b1);
    @(negedge clock);
    @(negedge clock);
    checkOutput("t6_rw_before", mem_rw, 1'b1);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6_async", {mem_rw, busy, m0_ack, m1_ack, grant}, 5'b0);
    m0_req = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    waitAck(0, 5, 32'h0, k, who, rwh, acc, rd, g);
    checkOutput("t6_no_ack", who, -1);
    applyStimulus(0, 0, 1'b1, 32'h60, 32'h66, 1'b1);
    applyStimulus(0, 1, 1'b1, 32'h70, 32'h77, 1'b0);
    pushExp(0, 0);
    expectAck(0, 3, 32'h0, "t6_tie", rwh, acc);
    m0_req = 1'b0;
    m1_req = 1'b0;

    $display("[TB] READ_LATENCY=3 read by master 1");
    applyStimulus(3, 1, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1);
    pushExp(1, 0);
    expectAck(3, 3, 32'h0, "t4_wr", rwh, acc);
    b_m1_req = 1'b0;
    applyStimulus(3, 1, 1'b0, 32'h20, 32'h0, 1'b1);
    pushExp(1, 32'hCAFEF00D);
    expectAck(3, 6, 32'h20, "t4_rd", rwh, acc);
    checkOutput("t4_addr_hold", acc, 4);
    checkOutput("t4_rw_never", rwh, 0);
    b_m1_req = 1'b0;

    checkOutput("sb_empty", sb.size(), 0);
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
